mem_responder: RTL

Synchronous word-addressed memory that answers the datapath's MAR/MDR memory requests. It is the responder end of the MDR's `Read`/`Mdatain` path: it captures an address and optional write data on a request edge, waits a configurable number of cycles, performs the access, and returns read data on `Mdatain` with a one-cycle `MemDone` pulse. It sits between the datapath's MAR/MDR and the rest of the system as the main memory model for simulation and synthesis.

---
 rtl/mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
//==============================================================================
// Module   : mem_responder
// Brief    : Word-addressed 32-bit memory that answers MAR/MDR read/write
//            requests. It detects request edges, inserts WAIT_CYCLES wait
//            states, performs one access and pulses MemDone for one cycle.
//            Optional macro: MEM_PARITY_EN stores an even-parity bit per word
//            and flags read parity mismatches on ParityErr.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    input  logic              ParInject,
    output logic [31:0]       Mdatain,
    output logic              MemDone,
    output logic              Busy,
    output logic              ParityErr
);

    localparam int         c_depth     = 1 << ADDR_W;
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic                r_read_d;
    logic                r_write_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic                r_is_write;
    logic [31:0]         r_mdatain;
    logic                w_rd_req;
    logic                w_wr_req;
    logic                w_accept;
    logic                w_busy;
    logic                w_done;

    assign w_rd_req = Read  & ~r_read_d;
    assign w_wr_req = Write & ~r_write_d;
    assign w_accept = (r_state == S_IDLE) & (w_rd_req | w_wr_req);

    // Previous request levels. They keep following the inputs while Clear is
    // held, so a level already high across reset release is not a new edge.
    always_ff @(posedge Clock) begin
        r_read_d  <= Read;
        r_write_d <= Write;
    end

    // State register, wait counter and request capture (write wins a tie).
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt      <= c_wait_load;
                r_addr     <= Address;
                r_data     <= DataIn;
                r_is_write <= w_wr_req;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_next_state = r_state;
        w_busy       = (r_state != S_IDLE);
        w_done       = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    assign Busy    = w_busy;
    assign MemDone = w_done;
    assign Mdatain = r_mdatain;

`ifdef MEM_PARITY_EN
    logic [32:0] r_mem [c_depth];
    logic        r_inj;
    logic        r_parity_err;

    // Injection flag captured alongside the rest of the request.
    always_ff @(posedge Clock) begin
        if (!Clear && w_accept) begin
            r_inj <= ParInject;
        end
    end

    // Array write: stored parity is even parity of the data, optionally flipped.
    always_ff @(posedge Clock) begin
        if (!Clear && (r_state == S_ACCESS) && r_is_write) begin
            r_mem[r_addr] <= {(^r_data) ^ r_inj, r_data};
        end
    end

    // Read data and parity check, both held until the next read access.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_mdatain    <= 32'd0;
            r_parity_err <= 1'b0;
        end else if ((r_state == S_ACCESS) && !r_is_write) begin
            r_mdatain    <= r_mem[r_addr][31:0];
            r_parity_err <= r_mem[r_addr][32] != (^r_mem[r_addr][31:0]);
        end
    end

    assign ParityErr = r_parity_err;
`else
    logic [31:0] r_mem [c_depth];
    logic        w_unused_parinj;

    assign w_unused_parinj = ParInject;

    // Array write; a Clear on the access edge cancels the store.
    always_ff @(posedge Clock) begin
        if (!Clear && (r_state == S_ACCESS) && r_is_write) begin
            r_mem[r_addr] <= r_data;
        end
    end

    // Read data register, held until the next read access.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_mdatain <= 32'd0;
        end else if ((r_state == S_ACCESS) && !r_is_write) begin
            r_mdatain <= r_mem[r_addr];
        end
    end

    assign ParityErr = 1'b0;
`endif

endmodule

`default_nettype wire
